// File: rtl/fcu_pkg.sv
// Shared constants for the fetch control unit: widths, opcodes, instruction
// field positions and redirect FSM state encodings.
package fcu_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned INS_W_DEF  = 32;

   localparam logic [5:0] OPC_LOAD_DEF = 6'h10;
   localparam logic [5:0] OPC_JMP_DEF  = 6'h20;
   localparam logic [5:0] OPC_BRZ_DEF  = 6'h21;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 26;
   localparam int unsigned RD_HI  = 25;
   localparam int unsigned RD_LO  = 21;
   localparam int unsigned RS_HI  = 20;
   localparam int unsigned RS_LO  = 16;
   localparam int unsigned RT_HI  = 15;
   localparam int unsigned RT_LO  = 11;
   localparam int unsigned IMM_HI = 15;
   localparam int unsigned IMM_LO = 0;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

endpackage

// File: rtl/fcu_hazard_detect.sv
// Combinational hazard/redirect detection from the IF/ID and ID/EX fields.
module fcu_hazard_detect
   import fcu_pkg::*;
#(
   parameter logic [5:0] OPC_LOAD = OPC_LOAD_DEF,
   parameter logic [5:0] OPC_JMP  = OPC_JMP_DEF,
   parameter logic [5:0] OPC_BRZ  = OPC_BRZ_DEF
) (
   input  logic [5:0] id_opc,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_valid,
   input  logic [5:0] ex_opc,
   input  logic [4:0] ex_rd,
   input  logic       ex_valid,
   input  logic       ex_zero,
   output logic       load_use,
   output logic       jmp_id,
   output logic       brz_taken
);

   always_comb begin
      load_use  = ex_valid && (ex_opc == OPC_LOAD) && (ex_rd != '0) && id_valid &&
                  ((id_rs == ex_rd) || (id_rt == ex_rd));
      jmp_id    = id_valid && (id_opc == OPC_JMP);
      brz_taken = ex_valid && (ex_opc == OPC_BRZ) && ex_zero;
   end

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch-side pipeline control: IF/ID and ID/EX registers, JMP/BRZ redirect
// with a one-cycle flush state, and load-use stall generation.
module fetch_control_unit
   import fcu_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned INS_W    = INS_W_DEF,
   parameter logic [5:0]  OPC_LOAD = OPC_LOAD_DEF,
   parameter logic [5:0]  OPC_JMP  = OPC_JMP_DEF,
   parameter logic [5:0]  OPC_BRZ  = OPC_BRZ_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INS_W-1:0]  ins,
   input  logic [ADDR_W-1:0] current_address,
   input  logic              ex_zero,
   output logic [ADDR_W-1:0] jump_loc,
   output logic              pc_mux_sel,
   output logic              stall,
   output logic              stall_pm,
   output logic [INS_W-1:0]  id_ins,
   output logic [ADDR_W-1:0] id_pc,
   output logic              id_valid,
   output logic [INS_W-1:0]  ex_ins,
   output logic [ADDR_W-1:0] ex_pc,
   output logic              ex_valid
);

   logic [0:0]        state_q;
   logic              load_use, jmp_id, brz_taken;
   logic              in_run, redirect_brz, redirect_jmp, hold;
   logic [ADDR_W-1:0] id_imm, ex_imm;

   fcu_hazard_detect #(
      .OPC_LOAD (OPC_LOAD),
      .OPC_JMP  (OPC_JMP),
      .OPC_BRZ  (OPC_BRZ)
   ) u_hazard (
      .id_opc    (id_ins[OPC_HI:OPC_LO]),
      .id_rs     (id_ins[RS_HI:RS_LO]),
      .id_rt     (id_ins[RT_HI:RT_LO]),
      .id_valid  (id_valid),
      .ex_opc    (ex_ins[OPC_HI:OPC_LO]),
      .ex_rd     (ex_ins[RD_HI:RD_LO]),
      .ex_valid  (ex_valid),
      .ex_zero   (ex_zero),
      .load_use  (load_use),
      .jmp_id    (jmp_id),
      .brz_taken (brz_taken)
   );

   // Priority: taken BRZ squashes a JMP in ID, which in turn overrides load-use.
   always_comb begin
      in_run       = (state_q == ST_RUN);
      redirect_brz = in_run && brz_taken;
      redirect_jmp = in_run && jmp_id && !brz_taken;
      hold         = in_run && load_use && !brz_taken && !jmp_id;
      id_imm       = ADDR_W'(id_ins[IMM_HI:IMM_LO]);
      ex_imm       = ADDR_W'(ex_ins[IMM_HI:IMM_LO]);
      pc_mux_sel   = redirect_brz || redirect_jmp;
      stall        = hold;
      stall_pm     = hold;
      jump_loc     = '0;
      if (redirect_brz)
         jump_loc = ex_pc + ADDR_W'(1) + ex_imm;
      else if (redirect_jmp)
         jump_loc = id_imm;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         id_ins   <= '0;
         id_pc    <= '0;
         id_valid <= 1'b0;
         ex_ins   <= '0;
         ex_pc    <= '0;
         ex_valid <= 1'b0;
      end else begin
         state_q <= pc_mux_sel ? ST_REDIRECT : ST_RUN;
         if (hold) begin
            ex_ins   <= '0;
            ex_pc    <= '0;
            ex_valid <= 1'b0;
         end else begin
            // Wrong-path fetch squashed on any redirect; JMP itself continues as a NOP.
            id_ins   <= ins;
            id_pc    <= current_address;
            id_valid <= !pc_mux_sel;
            ex_ins   <= id_ins;
            ex_pc    <= id_pc;
            ex_valid <= id_valid && !redirect_brz;
         end
      end
   end

endmodule
